// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encodings and
// chip-enable levels.
package inst_fetch_pkg;

    typedef enum logic {
        FETCH_INIT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous fetch buffer holding {pc,inst} pairs; a full buffer accepts a
// push when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == DEPTH_CNT);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale slots are never visible past the count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, ROM interface, fetch buffer and IF/ID
// valid/ready handshake with branch redirect and flush.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    fetch_state_e              r_state;
    logic                      r_ce;
    logic [ADDR_W-1:0]         r_pc;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_clear;
    logic                      w_valid;
    logic                      w_full;
    logic                      w_empty;
    logic [CNT_W-1:0]          w_count;
    logic [ADDR_W+INST_W-1:0]  w_dout;

    assign w_valid = ~w_empty;
    assign w_pop   = w_valid & id_ready_i;
    assign w_clear = branch_flag_i | flush_i;
    assign w_push  = (r_state == FETCH_RUN) & ~w_clear & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH_INIT;
            r_ce    <= CHIP_DISABLE;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                FETCH_INIT: begin
                    r_state <= FETCH_RUN;
                    r_ce    <= CHIP_ENABLE;
                end
                FETCH_RUN: begin
                    r_state <= FETCH_RUN;
                    r_ce    <= CHIP_ENABLE;
                end
                default: begin
                    r_state <= FETCH_INIT;
                    r_ce    <= CHIP_DISABLE;
                end
            endcase
            // A redirect overrides sequential advance, including during INIT.
            if (branch_flag_i)
                r_pc <= word_align(branch_target_i);
            else if (w_push)
                r_pc <= r_pc + ADDR_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W + INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clear (w_clear),
        .din   ({r_pc, rom_inst_i}),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rom_ce_o   = r_ce;
    assign rom_addr_o = word_align(r_pc);
    assign id_valid_o = w_valid;
    assign id_pc_o    = w_valid ? w_dout[ADDR_W+INST_W-1:INST_W] : '0;
    assign id_inst_o  = w_valid ? w_dout[INST_W-1:0] : '0;

    a_count_flags: assert property (@(posedge clk) disable iff (!rst)
        (w_empty == (w_count == '0)) && (w_full == (w_count == DEPTH_CNT)));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a queue-based reference model of the
// fetch buffer and PC.
module tb_inst_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        br = 1'b0;
    logic [31:0] br_tgt = '0;
    logic        fl = 1'b0;
    logic        id_valid;
    logic        ready = 1'b1;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    // ROM contents: word[i] = i
    assign rom_inst = {2'b00, rom_addr[31:2]};

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .rom_inst_i      (rom_inst),
        .branch_flag_i   (br),
        .branch_target_i (br_tgt),
        .flush_i         (fl),
        .id_valid_o      (id_valid),
        .id_ready_i      (ready),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a queue of {pc,inst} pairs, the PC and an init flag.
    logic [63:0] mq[$];
    logic [31:0] mpc   = '0;
    bit          minit = 1'b1;
    bit          m_pop;
    bit          m_push;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mpc   = '0;
            minit = 1'b1;
        end else begin
            m_pop  = (mq.size() != 0) && ready;
            m_push = !minit && !br && !fl && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (br || fl) mq.delete();
            if (m_push) mq.push_back({mpc, 2'b00, mpc[31:2]});
            if (br) mpc = br_tgt & ~32'h3;
            else if (m_push) mpc = mpc + 32'd4;
            minit = 1'b0;
        end
    end

    logic [31:0] e_pc;
    logic [31:0] e_inst;
    bit          e_valid;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_valid = (mq.size() != 0);
            e_pc    = e_valid ? mq[0][63:32] : 32'h0;
            e_inst  = e_valid ? mq[0][31:0]  : 32'h0;
            check("m_ce",    {31'b0, rom_ce},   {31'b0, !minit});
            check("m_addr",  rom_addr,          mpc);
            check("m_valid", {31'b0, id_valid}, {31'b0, e_valid});
            check("m_pc",    id_pc,             e_pc);
            check("m_inst",  id_inst,           e_inst);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_ce",    {31'b0, rom_ce},   32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_pc",    id_pc,             32'h0);
        check("rst_inst",  id_inst,           32'h0);

        // Reset release, continuous drain
        rst = 1'b1;
        check("init_ce", {31'b0, rom_ce}, 32'h0);
        cyc(1);
        check("run_ce",    {31'b0, rom_ce},   32'h1);
        check("run_addr0", rom_addr,          32'h0);
        check("run_val0",  {31'b0, id_valid}, 32'h0);
        cyc(1);
        check("t1_pc0",   id_pc,   32'h0);
        check("t1_inst0", id_inst, 32'h0);
        cyc(1);
        check("t1_pc4",   id_pc,   32'h4);
        check("t1_inst1", id_inst, 32'h1);
        cyc(1);
        check("t1_pc8",   id_pc,   32'h8);
        check("t1_inst2", id_inst, 32'h2);

        // Backpressure from an empty buffer, then full with pop every cycle
        br = 1'b1; br_tgt = 32'h0; ready = 1'b0;
        cyc(1);
        br = 1'b0;
        check("t2_empty", {31'b0, id_valid}, 32'h0);
        cyc(5);
        check("t2_hold_addr", rom_addr, 32'h8);
        check("t2_hold_pc",   id_pc,    32'h0);
        ready = 1'b1;
        cyc(1);
        check("t2_pc4",   id_pc,    32'h4);
        check("t3_addr",  rom_addr, 32'hC);
        cyc(1);
        check("t2_pc8",   id_pc,    32'h8);
        check("t3_addr2", rom_addr, 32'h10);
        cyc(1);
        check("t3_pc12",  id_pc,    32'hC);

        // Branch with a full buffer, unaligned target
        br = 1'b1; br_tgt = 32'h103;
        cyc(1);
        br = 1'b0;
        check("t4_valid", {31'b0, id_valid}, 32'h0);
        check("t4_addr",  rom_addr,          32'h100);
        cyc(1);
        check("t4_pc",   id_pc,   32'h100);
        check("t4_inst", id_inst, 32'h40);

        // PC wrap
        br = 1'b1; br_tgt = 32'hFFFF_FFFC;
        cyc(1);
        br = 1'b0;
        check("t5_top",  rom_addr, 32'hFFFF_FFFC);
        cyc(1);
        check("t5_wrap", rom_addr, 32'h0);
        check("t5_pc",   id_pc,    32'hFFFF_FFFC);
        check("t5_inst", id_inst,  32'h3FFF_FFFF);
        cyc(1);
        check("t5_pc0",  id_pc,    32'h0);

        // Branch and flush together
        br = 1'b1; fl = 1'b1; br_tgt = 32'h200;
        cyc(1);
        br = 1'b0; fl = 1'b0;
        check("bf_addr",  rom_addr,          32'h200);
        check("bf_valid", {31'b0, id_valid}, 32'h0);
        cyc(1);
        check("bf_pc", id_pc, 32'h200);

        // Flush alone keeps the PC
        fl = 1'b1;
        cyc(1);
        fl = 1'b0;
        check("fl_valid", {31'b0, id_valid}, 32'h0);
        check("fl_addr",  rom_addr,          32'h204);
        cyc(1);
        check("fl_pc", id_pc, 32'h204);

        // Reset mid-stream with a full buffer
        ready = 1'b0;
        cyc(3);
        check("t6_full_valid", {31'b0, id_valid}, 32'h1);
        rst = 1'b0;
        #1;
        check("t6_ce",    {31'b0, rom_ce},   32'h0);
        check("t6_valid", {31'b0, id_valid}, 32'h0);
        check("t6_pc",    id_pc,             32'h0);
        check("t6_inst",  id_inst,           32'h0);
        check("t6_addr",  rom_addr,          32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("t6_init_ce", {31'b0, rom_ce}, 32'h0);
        cyc(1);
        check("t6_run_ce", {31'b0, rom_ce}, 32'h1);
        check("t6_addr0",  rom_addr,        32'h0);
        ready = 1'b1;
        cyc(1);
        check("t6_first_valid", {31'b0, id_valid}, 32'h1);
        check("t6_first_pc",    id_pc,             32'h0);

        // Branch during INIT
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1; br = 1'b1; br_tgt = 32'h40;
        cyc(1);
        br = 1'b0;
        check("bi_ce",    {31'b0, rom_ce},   32'h1);
        check("bi_addr",  rom_addr,          32'h40);
        check("bi_valid", {31'b0, id_valid}, 32'h0);
        cyc(1);
        check("bi_pc",   id_pc,   32'h40);
        check("bi_inst", id_inst, 32'h10);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
